control_unit_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle processor control unit. It accepts one instruction word per valid/ready handshake and decodes it. It then sequences the memory read/write and ALU steps over several clock cycles, holding the A/B operand registers and carry/zero flags. It sits between the instruction register and the memory/ALU datapath, and adds memory handshaking with timeout, conditional store and halt.

---
 rtl/control_unit_mc.sv | 215 +++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: accepts one instruction per valid/ready handshake and
// sequences memory read/write and ALU steps, holding the A/B operands and carry/zero flags.
module control_unit_mc #(
    parameter int IR_W   = 16,
    parameter int OPC_W  = 3,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 9,
    parameter int MEM_TO = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IR_W-1:0]   ir_data,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cy,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd,
    output logic              wr,
    output logic [OPC_W-1:0]  opcode,
    output logic              alu_go,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              cy,
    output logic              zero,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    localparam int CNT_W = $clog2(MEM_TO + 1);

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LDB  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_STA  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_STZ  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_MEMRD,
        S_MEMWR,
        S_EXEC
    } state_t;

    state_t             state_reg, state_next;
    logic [OPC_W-1:0]   opcode_reg, opcode_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0]  imm_reg, imm_next;
    logic [DATA_W-1:0]  data_out_reg, data_out_next;
    logic [DATA_W-1:0]  a_reg, a_next;
    logic [DATA_W-1:0]  b_reg, b_next;
    logic               rd_reg, rd_next;
    logic               wr_reg, wr_next;
    logic               alu_go_reg, alu_go_next;
    logic               cy_reg, cy_next;
    logic               zero_reg, zero_next;
    logic               halted_reg, halted_next;
    logic               err_reg, err_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            opcode_reg   <= '0;
            addr_reg     <= '0;
            imm_reg      <= '0;
            data_out_reg <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            rd_reg       <= 1'b0;
            wr_reg       <= 1'b0;
            alu_go_reg   <= 1'b0;
            cy_reg       <= 1'b0;
            zero_reg     <= 1'b0;
            halted_reg   <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            opcode_reg   <= opcode_next;
            addr_reg     <= addr_next;
            imm_reg      <= imm_next;
            data_out_reg <= data_out_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            rd_reg       <= rd_next;
            wr_reg       <= wr_next;
            alu_go_reg   <= alu_go_next;
            cy_reg       <= cy_next;
            zero_reg     <= zero_next;
            halted_reg   <= halted_next;
            err_reg      <= err_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        opcode_next   = opcode_reg;
        addr_next     = addr_reg;
        imm_next      = imm_reg;
        data_out_next = data_out_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        rd_next       = rd_reg;
        wr_next       = wr_reg;
        alu_go_next   = 1'b0;
        cy_next       = cy_reg;
        zero_next     = zero_reg;
        halted_next   = halted_reg;
        err_next      = err_reg;
        cnt_next      = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (ir_valid && !halted_reg) begin
                    opcode_next = ir_data[IR_W-1 -: OPC_W];
                    addr_next   = ir_data[IR_W-OPC_W-1 -: ADDR_W];
                    imm_next    = ir_data[DATA_W-1:0];
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_IDLE;
                case (opcode_reg)
                    OP_LDI:  a_next = imm_reg;
                    OP_LDA, OP_LDB: begin
                        cnt_next   = '0;
                        state_next = S_MEMRD;
                    end
                    OP_STA: begin
                        data_out_next = a_reg;
                        cnt_next      = '0;
                        state_next    = S_MEMWR;
                    end
                    OP_STZ: begin
                        if (zero_reg) begin
                            data_out_next = a_reg;
                            cnt_next      = '0;
                            state_next    = S_MEMWR;
                        end
                    end
                    OP_ADD: begin
                        alu_go_next = 1'b1;
                        state_next  = S_EXEC;
                    end
                    OP_HALT: halted_next = 1'b1;
                    default: state_next = S_IDLE;
                endcase
            end
            // First cycle in a memory state raises the request; ack is honoured only while it is up.
            S_MEMRD: begin
                if (!rd_reg) begin
                    rd_next = 1'b1;
                end else if (mem_ack) begin
                    if (opcode_reg == OP_LDA) a_next = mem_rdata;
                    else                      b_next = mem_rdata;
                    rd_next    = 1'b0;
                    state_next = S_IDLE;
                end else if (cnt_reg == CNT_W'(MEM_TO - 1)) begin
                    rd_next    = 1'b0;
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_MEMWR: begin
                if (!wr_reg) begin
                    wr_next = 1'b1;
                end else if (mem_ack) begin
                    wr_next    = 1'b0;
                    state_next = S_IDLE;
                end else if (cnt_reg == CNT_W'(MEM_TO - 1)) begin
                    wr_next    = 1'b0;
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_EXEC: begin
                a_next     = alu_out;
                cy_next    = alu_cy;
                zero_next  = (alu_out == '0);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ir_ready = (state_reg == S_IDLE) && !halted_reg;
    assign busy     = (state_reg != S_IDLE);
    assign addr     = addr_reg;
    assign data_out = data_out_reg;
    assign rd       = rd_reg;
    assign wr       = wr_reg;
    assign opcode   = opcode_reg;
    assign alu_go   = alu_go_reg;
    assign A        = a_reg;
    assign B        = b_reg;
    assign cy       = cy_reg;
    assign zero     = zero_reg;
    assign halted   = halted_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: directed and random instructions against a behavioural
// model of the programmer-visible state and an attached memory/ALU.
module tb_control_unit_mc;

    localparam int DW = 9;
    localparam int AW = 3;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   ir_data;
    logic          ir_valid;
    logic          ir_ready;
    logic [DW-1:0] alu_out;
    logic          alu_cy;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_out;
    logic          rd, wr;
    logic [2:0]    opcode;
    logic          alu_go;
    logic [DW-1:0] A, B;
    logic          cy, zero, busy, halted, err;

    control_unit_mc #(
        .IR_W(16), .OPC_W(3), .ADDR_W(AW), .DATA_W(DW), .MEM_TO(TO)
    ) dut (
        .clk(clk), .rst(rst), .ir_data(ir_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .alu_out(alu_out), .alu_cy(alu_cy), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .addr(addr), .data_out(data_out), .rd(rd), .wr(wr), .opcode(opcode), .alu_go(alu_go),
        .A(A), .B(B), .cy(cy), .zero(zero), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [8];
    logic [DW-1:0] m_a, m_b;
    logic          m_cy, m_zero, m_halted, m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ir_valid = 1'b0; mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        m_a = '0; m_b = '0; m_cy = 1'b0; m_zero = 1'b0; m_halted = 1'b0; m_err = 1'b0;
    endtask

    // Offers one instruction, plays memory and ALU until the unit is idle, then checks the model.
    // dly = k acknowledges in the k-th request cycle; dly = 0 never acknowledges.
    task automatic run_instr(input logic [15:0] ir, input int dly);
        logic [2:0]    op, ad;
        logic [DW-1:0] im, wdata;
        logic [DW:0]   sum;
        bit            take_mem, tmo, is_st;
        int            exp_cyc, exp_req, cyc, req, gos, overlap;
        op = ir[15:13]; ad = ir[12:10]; im = ir[DW-1:0];
        sum = {1'b0, m_a} + {1'b0, m_b};
        take_mem = (op == 1) || (op == 2) || (op == 3) || (op == 6 && m_zero);
        is_st    = take_mem && (op == 3 || op == 6);
        tmo      = take_mem && (dly == 0);
        exp_req  = take_mem ? (tmo ? TO : dly) : 0;
        exp_cyc  = (op == 5) ? 2 : (take_mem ? 2 + exp_req : 1);
        wdata = '0;

        check("ready_before", ir_ready, !m_halted);
        ir_data = ir; ir_valid = 1'b1;
        alu_out = sum[DW-1:0]; alu_cy = sum[DW];
        tick();
        ir_valid = 1'b0; ir_data = 16'($urandom);
        if (m_halted) begin
            check("halted_busy", busy, 1'b0);
            check("halted_ready", ir_ready, 1'b0);
            check("halted_flag", halted, 1'b1);
            $display("instr ir=%04h ignored (halted)", ir);
            return;
        end
        check("opcode", opcode, op);
        check("addr", addr, ad);
        check("busy_accept", busy, 1'b1);

        cyc = 0; req = 0; gos = 0; overlap = 0;
        while (busy === 1'b1 && cyc < 40) begin
            if (rd && wr) overlap++;
            if (alu_go) gos++;
            if (rd || wr) begin
                req++;
                if (wr) wdata = data_out;
                if (dly != 0 && req == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd ? mem[ad] : DW'($urandom);
                    if (wr) mem[ad] = m_a;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = DW'($urandom);
                end
            end else begin
                mem_ack = take_mem ? 1'b0 : 1'($urandom);
                mem_rdata = DW'($urandom);
            end
            tick();
            cyc++;
            mem_ack = 1'b0;
        end
        check("done_in_budget", busy, 1'b0);

        case (op)
            3'd1: if (!tmo) m_a = mem[ad];
            3'd2: if (!tmo) m_b = mem[ad];
            3'd4: m_a = im;
            3'd5: begin m_a = sum[DW-1:0]; m_cy = sum[DW]; m_zero = (sum[DW-1:0] == 0); end
            3'd7: m_halted = 1'b1;
            default: ;
        endcase
        if (tmo) m_err = 1'b1;

        check("cycles", cyc, exp_cyc);
        check("req_cycles", req, exp_req);
        check("alu_go_pulses", gos, (op == 5) ? 1 : 0);
        check("rd_wr_overlap", overlap, 0);
        if (is_st) begin
            check("wdata", wdata, m_a);
            check("data_out", data_out, m_a);
        end
        check("A", A, m_a);
        check("B", B, m_b);
        check("cy", cy, m_cy);
        check("zero", zero, m_zero);
        check("err", err, m_err);
        check("halted", halted, m_halted);
        check("rd_wr_idle", {rd, wr}, 2'b00);
        check("ready_after", ir_ready, !m_halted);
        $display("instr ir=%04h op=%0d addr=%0d dly=%0d cycles=%0d A=%03h B=%03h cy=%0b z=%0b err=%0b",
                 ir, op, ad, dly, cyc, A, B, cy, zero, err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ir_data = '0; ir_valid = 1'b0; alu_out = '0; alu_cy = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0; rst = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
        mem[3] = 9'h1AB;
        mem[2] = 9'h100;

        // reset values
        tick();
        do_reset();
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_addr", addr, 0);
        check("rst_data_out", data_out, 0);
        check("rst_opcode", opcode, 0);
        check("rst_ctl", {rd, wr, alu_go}, 3'b000);
        check("rst_flags", {cy, zero, halted, err}, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ir_ready, 1'b1);
        $display("reset checked");

        // directed sequence
        run_instr(16'h8005, 0);                       // LDI 5
        run_instr({3'd1, 3'd3, 10'h000}, 4);          // LDA 3, ack in 4th rd cycle
        run_instr({3'd4, 3'd0, 1'b0, 9'h100}, 0);     // LDI 0x100
        run_instr({3'd2, 3'd2, 10'h000}, 1);          // LDB 2 (0x100)
        run_instr({3'd5, 3'd0, 10'h000}, 0);          // ADD -> 0, cy=1, zero=1
        run_instr({3'd6, 3'd6, 10'h000}, 2);          // STZ taken
        run_instr({3'd4, 3'd0, 1'b0, 9'h001}, 0);     // LDI 1
        run_instr({3'd5, 3'd0, 10'h000}, 0);          // ADD -> 0x101, zero=0
        run_instr({3'd6, 3'd5, 10'h000}, 3);          // STZ skipped
        run_instr({3'd3, 3'd4, 10'h000}, 0);          // STA with no ack -> timeout
        run_instr({3'd4, 3'd0, 1'b0, 9'h007}, 0);     // still accepted after err
        run_instr({3'd0, 3'd1, 10'h155}, 0);          // NOP

        // random instructions, HALT excluded
        for (int n = 0; n < 80; n++) begin
            logic [15:0] rir;
            int rdly;
            rir = 16'($urandom);
            if (rir[15:13] == 3'd7) rir[15:13] = 3'($urandom_range(0, 6));
            rdly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
            run_instr(rir, rdly);
        end

        // reset while reading
        ir_data = {3'd1, 3'd5, 10'h000}; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick(); tick(); tick();
        check("mid_rd_high", rd, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_a = '0; m_b = '0; m_cy = 1'b0; m_zero = 1'b0; m_halted = 1'b0; m_err = 1'b0;
        check("abort_rd", rd, 1'b0);
        check("abort_A", A, 0);
        check("abort_busy", busy, 1'b0);
        mem_ack = 1'b1; mem_rdata = 9'h0FF;
        tick(); tick();
        mem_ack = 1'b0;
        check("late_ack_A", A, 0);
        check("late_ack_busy", busy, 1'b0);
        $display("reset during read checked");

        // halt blocks further instructions until reset
        run_instr({3'd4, 3'd0, 1'b0, 9'h033}, 0);
        run_instr({3'd7, 3'd0, 10'h000}, 0);
        for (int k = 0; k < 3; k++) run_instr({3'd4, 3'd0, 1'b0, 9'h0AA}, 0);
        check("halt_A_kept", A, 9'h033);
        do_reset();
        check("unhalt_flag", halted, 1'b0);
        check("unhalt_ready", ir_ready, 1'b1);
        run_instr({3'd4, 3'd0, 1'b0, 9'h012}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
